fetch_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end: generates sequential PCs, issues requests to
//  an instruction memory with variable latency, buffers returned words with their PCs in a

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int PC_INC_DEF = 1;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: power-of-two circular buffer with push/pop/flush.
// Flush wins over a same-cycle push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  entry_t      push_data,
  input  logic        pop,
  input  logic        flush,
  output entry_t      head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  // A full queue may still accept a push when its head leaves in the same cycle.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// prefetch queue to decode, redirect flush. Optional counters under FETCH_PERF_EN.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int QDEPTH = 4,
  parameter int PC_INC = PC_INC_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_drops,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            fifo_full;
  logic            fifo_empty;
  logic            req_fire;
  logic            resp_keep;
  entry_t          push_entry;
  entry_t          head;

  // Queue entries plus outstanding requests never exceed QDEPTH, so a response always has a slot.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight};
  assign imem_req_valid = rst & (occupancy < (CW+1)'(QDEPTH)) & ~fifo_full & ~redirect_valid;
  assign imem_req_addr  = req_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_keep      = imem_resp_valid & (drop == '0);
  assign inflight_nxt   = inflight + CW'(req_fire) - CW'(imem_resp_valid);
  assign push_entry     = '{pc: resp_pc, instr: imem_resp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc   <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        req_pc  <= redirect_pc;
        resp_pc <= redirect_pc;
        drop    <= inflight_nxt;
      end else begin
        if (req_fire) req_pc <= req_pc + XLEN'(PC_INC);
        if (imem_resp_valid) begin
          if (drop != '0) drop <= drop - 1'b1;
          else            resp_pc <= resp_pc + XLEN'(PC_INC);
        end
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (out_valid & out_ready),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : '0;

`ifdef FETCH_PERF_EN
  // Responses landing during a redirect are thrown away too, so they count as drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_redirects    <= '0;
      perf_drops        <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (redirect_valid && perf_redirects != '1)
        perf_redirects <= perf_redirects + 1'b1;
      if (imem_resp_valid && (drop != '0 || redirect_valid) && perf_drops != '1)
        perf_drops <= perf_drops + 1'b1;
      if (out_valid && !out_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios then random traffic against a
// request/epoch model of imem and decode. Define FETCH_PERF_EN to cover the counters.
module tb_fetch_prefetch_queue;

  localparam int QD = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_drops;
  logic [31:0] perf_stall_cycles;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          epoch    = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          dut_fires;
  logic [31:0] exp_req;
  req_t        imem_q[$];
  logic [31:0] model_q[$];

  fetch_prefetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_drops        (perf_drops),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    checkOutput({tag, "_req_addr"},  imem_req_addr, 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_pc"},    out_pc, 32'd0);
    checkOutput({tag, "_out_instr"}, out_instr, 32'd0);
  endtask

  task automatic clearModel();
    imem_q.delete();
    model_q.delete();
    exp_req  = 32'd0;
    last_due = cyc;
    epoch++;
  endtask

  task automatic resetDut();
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;
    clearModel();
    @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check against the model, advance it.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic oready, input logic rready);
    logic resp_now;
    logic exp_rv;
    req_t r;
    int   due;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = oready;
    imem_req_ready = rready;
    resp_now       = (imem_q.size() != 0) && (imem_q[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(imem_q[0].addr) : 32'd0;
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkOutput("out_pc", out_pc, model_q[0]);
      checkOutput("out_instr", out_instr, mem_word(model_q[0]));
    end
    exp_rv = ((model_q.size() + imem_q.size()) < QD) && !redir;
    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) checkOutput("req_addr", imem_req_addr, exp_req);
    if (imem_req_valid && rready) dut_fires++;
    if (resp_now) r = imem_q.pop_front();
    if (redir) begin
      model_q.delete();
      epoch++;
      exp_req = rpc;
    end else begin
      if (oready && model_q.size() != 0) void'(model_q.pop_front());
      if (resp_now && r.epoch == epoch) model_q.push_back(r.addr);
      if (exp_rv && rready) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        imem_q.push_back('{addr: exp_req, due: due, epoch: epoch});
        exp_req = exp_req + 32'd1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic        seen;
    logic        found;
    logic [31:0] first_pc;
    rst = 1'b0;
    dut_fires = 0;
    @(negedge clk);

    // Zero-wait memory, decode always ready: sequential PCs stream out.
    resetDut();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

    // Decode stalled: only QD requests go out and the head stays at PC 0.
    resetDut();
    dut_fires = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stall_req_count", 32'(dut_fires), 32'd4);
    checkOutput("stall_head_pc", out_pc, 32'd0);

    // Slow memory with requests outstanding, then redirect: stale words must vanish.
    resetDut();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("redir_inflight_ge2", 32'(imem_q.size() >= 2), 32'd1);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
    seen = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 20; i++) begin
      if (!seen && out_valid) begin
        seen = 1'b1;
        first_pc = out_pc;
      end
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    end
    checkOutput("redir_first_pc", first_pc, 32'h100);

    // Redirect in a cycle that also pushes and pops: queue must be empty afterwards.
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (model_q.size() != 0 && imem_q.size() != 0 && imem_q[0].due <= cyc) begin
        found = 1'b1;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        checkOutput("flush_empty", 32'(out_valid), 32'd0);
      end else begin
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
      end
    end
    checkOutput("flush_case_found", 32'(found), 32'd1);

    // PC wrap at the top of the address space, then reset in the middle of the burst.
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    rst = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    checkResetOutputs("midreset");
    resetDut();

`ifdef FETCH_PERF_EN
    // Three redirects and exactly five stalled cycles with a valid head.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40 * i, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("perf_redirects", perf_redirects, 32'd3);
    checkOutput("perf_stall_cycles", perf_stall_cycles, 32'd5);
    resetDut();
`endif

    // Random traffic: variable latency, backpressure on both sides, occasional redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(19, 0) == 0), $urandom,
                    ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
